rpn_stack_alu: RTL and testbench

- Parametrised stack-machine execution unit for the RPN calculator datapath; sits between the UART command decoder and the result formatter.
- Holds an internal operand stack and executes one RPN command at a time.
- Adds a multi-cycle divider, a valid/ready command handshake, stack-management ops and error reporting.
- Generalised in operand width and stack depth.

---
 rtl/rpn_stack_alu.sv | 245 ++++++++++++++++++++++++
 tb/tb_rpn_stack_alu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_alu.sv
`timescale 1ns/1ps
// rpn_stack_alu: operand stack plus ALU for the RPN calculator datapath.
// Single-cycle ops commit in the accept cycle; DIV runs a WIDTH-cycle restoring divider.
module rpn_stack_alu #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_err,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_POP  = 4'd4;
    localparam logic [3:0] OP_PUSH = 4'd5;
    localparam logic [3:0] OP_DUP  = 4'd6;
    localparam logic [3:0] OP_SWAP = 4'd7;
    localparam logic [3:0] OP_CLR  = 4'd8;

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_UNDER = 3'd1;
    localparam logic [2:0] ERR_OVER  = 3'd2;
    localparam logic [2:0] ERR_DIV0  = 3'd3;
    localparam logic [2:0] ERR_OP    = 3'd4;

    typedef enum logic {S_IDLE, S_DIV} state_t;

    // Error classification in priority order: opcode, stack bounds, divisor.
    function automatic logic [2:0] cmd_check(input logic [3:0]       op,
                                             input logic [DW-1:0]    dep,
                                             input logic [WIDTH-1:0] t_val);
        logic need2;
        logic need1;
        logic grows;
        need2 = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
                (op == OP_DIV) || (op == OP_SWAP);
        need1 = (op == OP_POP) || (op == OP_DUP);
        grows = (op == OP_PUSH) || (op == OP_DUP);
        if (op > OP_CLR)
            return ERR_OP;
        if ((need2 && dep < DW'(2)) || (need1 && dep == '0))
            return ERR_UNDER;
        if (grows && dep == DW'(DEPTH))
            return ERR_OVER;
        if (op == OP_DIV && t_val == '0)
            return ERR_DIV0;
        return ERR_OK;
    endfunction

    // One restoring-division step: returns {remainder, quotient/dividend shift}.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvsr);
        logic [WIDTH:0]   trial;
        logic [WIDTH-1:0] diff;
        trial = {rem, quo[WIDTH-1]};
        diff  = trial[WIDTH-1:0] - dvsr;
        if (trial >= {1'b0, dvsr})
            return {diff, quo[WIDTH-2:0], 1'b1};
        return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    endfunction

    logic [WIDTH-1:0]   mem [DEPTH];
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic [WIDTH-1:0]   top_q, top_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [2:0]         rsp_err_q, rsp_err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [2:0]         chk_err;
    logic [AW-1:0]      idx_t, idx_s, idx_p;
    logic [WIDTH-1:0]   t_val, s_val, alu_res;
    logic [2*WIDTH-1:0] step;
    logic               wr0_en, wr1_en;
    logic [AW-1:0]      wr0_addr, wr1_addr;
    logic [WIDTH-1:0]   wr0_data, wr1_data;

    assign idx_t   = AW'(depth_q - DW'(1));
    assign idx_s   = AW'(depth_q - DW'(2));
    assign idx_p   = AW'(depth_q);
    assign t_val   = (depth_q >= DW'(1)) ? mem[idx_t] : '0;
    assign s_val   = (depth_q >= DW'(2)) ? mem[idx_s] : '0;
    assign chk_err = cmd_check(cmd_op, depth_q, t_val);
    assign step    = div_step(rem_q, quo_q, dvsr_q);

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign top       = top_q;
    assign depth     = depth_q;

    always_comb begin
        case (cmd_op)
            OP_ADD:  alu_res = s_val + t_val;
            OP_SUB:  alu_res = s_val - t_val;
            default: alu_res = s_val * t_val;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        depth_d     = depth_q;
        top_d       = top_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        wr0_en      = 1'b0;
        wr0_addr    = idx_s;
        wr0_data    = t_val;
        wr1_en      = 1'b0;
        wr1_addr    = idx_t;
        wr1_data    = s_val;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (chk_err != ERR_OK) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = chk_err;
                        rsp_data_d  = top_q;
                    end else if (cmd_op == OP_DIV) begin
                        // Dividend shifts out of quo_q as quotient bits shift in.
                        state_d = S_DIV;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = s_val;
                        dvsr_d  = t_val;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_OK;
                        case (cmd_op)
                            OP_ADD, OP_SUB, OP_MUL: begin
                                wr0_en     = 1'b1;
                                wr0_data   = alu_res;
                                depth_d    = depth_q - DW'(1);
                                top_d      = alu_res;
                                rsp_data_d = alu_res;
                            end
                            OP_POP: begin
                                depth_d    = depth_q - DW'(1);
                                top_d      = s_val;
                                rsp_data_d = t_val;
                            end
                            OP_PUSH: begin
                                wr0_en     = 1'b1;
                                wr0_addr   = idx_p;
                                wr0_data   = cmd_data;
                                depth_d    = depth_q + DW'(1);
                                top_d      = cmd_data;
                                rsp_data_d = cmd_data;
                            end
                            OP_DUP: begin
                                wr0_en     = 1'b1;
                                wr0_addr   = idx_p;
                                depth_d    = depth_q + DW'(1);
                                top_d      = t_val;
                                rsp_data_d = t_val;
                            end
                            OP_SWAP: begin
                                wr0_en     = 1'b1;
                                wr1_en     = 1'b1;
                                top_d      = s_val;
                                rsp_data_d = s_val;
                            end
                            default: begin
                                depth_d    = '0;
                                top_d      = '0;
                                rsp_data_d = '0;
                            end
                        endcase
                    end
                end
            end
            default: begin
                rem_d = step[2*WIDTH-1:WIDTH];
                quo_d = step[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    wr0_en      = 1'b1;
                    wr0_data    = step[WIDTH-1:0];
                    depth_d     = depth_q - DW'(1);
                    top_d       = step[WIDTH-1:0];
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = step[WIDTH-1:0];
                    rsp_err_d   = ERR_OK;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            depth_q     <= '0;
            top_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            depth_q     <= depth_d;
            top_q       <= top_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Stack storage and divider datapath carry no reset; depth gates visibility.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvsr_q <= dvsr_d;
        if (wr0_en)
            mem[wr0_addr] <= wr0_data;
        if (wr1_en)
            mem[wr1_addr] <= wr1_data;
    end

endmodule

// File: tb/tb_rpn_stack_alu.sv
`timescale 1ns/1ps
// Bench for rpn_stack_alu: directed scenarios then random commands against a queue-based stack model.
module tb_rpn_stack_alu;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = 4'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_err;
    logic [WIDTH-1:0] top;
    logic [DW-1:0]    depth;

    int n_checks = 0;
    int n_err = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [15:0] mdl[$];

    rpn_stack_alu #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .top(top), .depth(depth)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rsp_valid) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: stack as a queue, rules applied directly.
    task automatic model(input logic [3:0] op, input logic [15:0] data,
                         output logic [2:0] e_err, output logic [15:0] e_data);
        int n;
        logic [15:0] t, s, r;
        n = mdl.size();
        t = (n >= 1) ? mdl[n-1] : 16'd0;
        s = (n >= 2) ? mdl[n-2] : 16'd0;
        if (op > 4'd8) e_err = 3'd4;
        else if (((op <= 4'd3 || op == 4'd7) && n < 2) || ((op == 4'd4 || op == 4'd6) && n < 1)) e_err = 3'd1;
        else if ((op == 4'd5 || op == 4'd6) && n == DEPTH) e_err = 3'd2;
        else if (op == 4'd3 && t == 16'd0) e_err = 3'd3;
        else e_err = 3'd0;
        e_data = t;
        if (e_err == 3'd0) begin
            case (op)
                4'd0, 4'd1, 4'd2, 4'd3: begin
                    void'(mdl.pop_back());
                    void'(mdl.pop_back());
                    if (op == 4'd0) r = s + t;
                    else if (op == 4'd1) r = s - t;
                    else if (op == 4'd2) r = 16'((32'(s) * 32'(t)) % 65536);
                    else r = s / t;
                    mdl.push_back(r);
                    e_data = r;
                end
                4'd4: begin void'(mdl.pop_back()); e_data = t; end
                4'd5: begin mdl.push_back(data); e_data = data; end
                4'd6: begin mdl.push_back(t); e_data = t; end
                4'd7: begin
                    void'(mdl.pop_back());
                    void'(mdl.pop_back());
                    mdl.push_back(t);
                    mdl.push_back(s);
                    e_data = s;
                end
                default: begin mdl.delete(); e_data = 16'd0; end
            endcase
        end
    endtask

    task automatic exec(input logic [3:0] op, input logic [15:0] data);
        logic [2:0]  e_err;
        logic [15:0] e_data, e_top, pre_top;
        int          pre_depth, n;
        bit          is_div;
        pre_depth = mdl.size();
        pre_top = (pre_depth > 0) ? mdl[pre_depth-1] : 16'd0;
        model(op, data, e_err, e_data);
        e_top = (mdl.size() > 0) ? mdl[mdl.size()-1] : 16'd0;
        is_div = (op == 4'd3) && (e_err == 3'd0);
        @(negedge clk);
        check("ready_pre", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (is_div) begin
            cmd_valid = 1'b1;
            cmd_op = 4'd5;
            cmd_data = 16'($urandom);
            n = 0;
            while (!rsp_valid && n < 40) begin
                check("div_busy", 32'(cmd_ready), 32'd0);
                check("div_depth_hold", 32'(depth), 32'(pre_depth));
                check("div_top_hold", 32'(top), 32'(pre_top));
                @(posedge clk);
                #1;
                n++;
            end
            cmd_valid = 1'b0;
            check("div_latency", 32'(n), 32'(WIDTH));
        end
        exp_pulses++;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("rsp_data", 32'(rsp_data), 32'(e_data));
        check("top", 32'(top), 32'(e_top));
        check("depth", 32'(depth), 32'(mdl.size()));
    endtask

    initial begin
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_top", 32'(top), 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic and back-to-back accepts
        exec(4'd5, 16'd7); exec(4'd5, 16'd5); exec(4'd1, 16'd0);
        check("t1_sub", 32'(rsp_data), 32'd2);
        exec(4'd5, 16'd3); exec(4'd2, 16'd0);
        check("t1_mul", 32'(rsp_data), 32'd6);
        // Division
        exec(4'd8, 16'd0); exec(4'd5, 16'd100); exec(4'd5, 16'd7); exec(4'd3, 16'd0);
        check("t2_div", 32'(rsp_data), 32'd14);
        exec(4'd5, 16'd1);
        // Divide by zero
        exec(4'd8, 16'd0); exec(4'd5, 16'd1); exec(4'd5, 16'd0); exec(4'd3, 16'd0);
        check("t3_err", 32'(rsp_err), 32'd3);
        // Overflow / underflow
        exec(4'd8, 16'd0);
        for (int i = 1; i <= 4; i++) exec(4'd5, 16'(i));
        exec(4'd5, 16'd9);
        check("t4_over", 32'(rsp_err), 32'd2);
        exec(4'd6, 16'd0); exec(4'd8, 16'd0); exec(4'd0, 16'd0);
        check("t4_under", 32'(rsp_err), 32'd1);
        exec(4'd4, 16'd0);
        // Wraparound and bad opcode
        exec(4'd8, 16'd0); exec(4'd5, 16'hFFFF); exec(4'd5, 16'd2); exec(4'd0, 16'd0);
        check("t5_add_wrap", 32'(rsp_data), 32'h0001);
        exec(4'd5, 16'd0); exec(4'd5, 16'd1); exec(4'd1, 16'd0);
        check("t5_sub_wrap", 32'(rsp_data), 32'hFFFF);
        exec(4'd8, 16'd0); exec(4'd5, 16'h0100); exec(4'd5, 16'h0100); exec(4'd2, 16'd0);
        check("t5_mul_wrap", 32'(rsp_data), 32'h0000);
        exec(4'hF, 16'd0);
        check("t5_badop", 32'(rsp_err), 32'd4);

        // Reset in the middle of a division
        exec(4'd8, 16'd0); exec(4'd5, 16'd50); exec(4'd5, 16'd5);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_data = 16'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("t6_div_busy", 32'(cmd_ready), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_ready", 32'(cmd_ready), 32'd1);
        check("t6_valid", 32'(rsp_valid), 32'd0);
        check("t6_data", 32'(rsp_data), 32'd0);
        check("t6_err", 32'(rsp_err), 32'd0);
        check("t6_top", 32'(top), 32'd0);
        check("t6_depth", 32'(depth), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl.delete();
        repeat (20) @(negedge clk);
        check("t6_no_pulse", 32'(pulses), 32'(exp_pulses));
        check("t6_depth_after", 32'(depth), 32'd0);
        exec(4'd5, 16'h1234);

        // Random commands
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [3:0]  op;
            logic [15:0] d;
            r = $urandom_range(0, 99);
            if (r < 35) op = 4'd5;
            else if (r < 93) op = 4'($urandom_range(0, 8));
            else op = 4'($urandom_range(9, 15));
            d = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            exec(op, d);
        end

        @(negedge clk);
        @(negedge clk);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
